counter_param: RTL and testbench
================================

COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MAX_VAL, default 2**WIDTH-1: terminal count; legal range 1..2**WIDTH-1.
REQ-003 Parameter PRESCALE, default 1: enabled cycles per count step; legal range 1..256.
REQ-004 The block SHALL use one clock, and reset SHALL be asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock, the only clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 count_en  in  1  advances prescaler; holds counter when low.
REQ-008 up_dn  in  1  1 = count up, 0 = count down.
REQ-009 sat_mode  in  1  1 = saturate at boundary, 0 = wrap.
REQ-010 clear  in  1  synchronous clear of counter, prescaler and ovf.
REQ-011 load  in  1  synchronous load of load_val.
REQ-012 load_val  in  WIDTH  load value.
REQ-013 q_out  out  WIDTH  registered count value.
REQ-014 tc  out  1  registered one-cycle terminal-count pulse.
REQ-015 ovf  out  1  sticky boundary-hit flag.

Function
REQ-016 Per-edge priority SHALL be reset > clear > load > step; at most one of these acts per edge.
REQ-017 clear SHALL set q_out=0, prescaler=0, ovf=0 and tc=0 on the next edge.
REQ-018 load SHALL set q_out=min(load_val, MAX_VAL) and prescaler=0 and tc=0; ovf is unchanged.
REQ-019 The prescaler SHALL be a 0..PRESCALE-1 counter that advances only on edges where count_en=1 and neither clear nor load is asserted; it holds its value when count_en=0.
REQ-020 A step event SHALL occur on an edge where count_en=1, the prescaler equals PRESCALE-1, and neither clear nor load is asserted; the prescaler returns to 0 on that edge.
REQ-021 With PRESCALE=1, every enabled edge SHALL be a step event (single-cycle latency from count_en to q_out change).
REQ-022 Step, up direction: if q_out<MAX_VAL, q_out SHALL become q_out+1; at q_out=MAX_VAL, wrap mode SHALL give 0 and saturate mode SHALL hold MAX_VAL.
REQ-023 Step, down direction: if q_out>0, q_out SHALL become q_out-1; at q_out=0, wrap mode SHALL give MAX_VAL and saturate mode SHALL hold 0.
REQ-024 A boundary hit SHALL be a step event that starts with q_out at the boundary in the current direction (MAX_VAL going up, 0 going down).
REQ-025 On a boundary hit, tc SHALL be 1 for exactly the following cycle (registered with q_out), and ovf SHALL be set to 1.
REQ-026 tc SHALL be 0 in every cycle not immediately preceded by a boundary hit; back-to-back hits SHALL keep tc high on each such cycle.
REQ-027 up_dn and sat_mode SHALL be sampled on every edge; a change takes effect on the next step with no pipeline delay.
REQ-028 q_out SHALL never exceed MAX_VAL, including after load and after a direction change.
REQ-029 ovf SHALL stay at 1 until clear or reset.
REQ-030 Elaboration SHALL fail with an error if any parameter is outside its legal range.

Reset
REQ-031 While reset=1, q_out=0, prescaler=0, tc=0 and ovf=0 immediately, without waiting for a clk edge.
REQ-032 reset deassertion mid-operation SHALL resume from q_out=0; the first step occurs PRESCALE enabled edges after release.

Verification
REQ-033 WIDTH=4, MAX_VAL=9, PRESCALE=1, up, wrap, count_en=1 from 0 -> q_out 0..9,0; tc high the cycle q_out=0 reappears; ovf=1 thereafter.
REQ-034 Same config, sat_mode=1, 12 steps -> q_out holds 9; tc pulses on each step taken at 9; q_out never 10.
REQ-035 Down, wrap, start 0 -> q_out 9, then 8; tc high with the 9; load_val=15 loaded -> q_out=9.
REQ-036 PRESCALE=3, up, count_en toggling 1,1,0,1 -> exactly one increment, on the third enabled edge.
REQ-037 clear and load asserted together with count_en at q_out=5 -> q_out=0, ovf=0, no step; a later load=1 with count_en -> q_out=load_val, no step.
REQ-038 reset pulse asynchronous to clk at q_out=7, ovf=1 -> q_out=0, ovf=0, tc=0 before the next clk edge.

Source files
------------

// File: rtl/counter_param.sv
`default_nettype none
// ============================================================================
// Module      : counter_param
// Description : Parameterised up/down counter with prescaler, wrap/saturate
//               modes, terminal-count pulse and sticky boundary flag.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_param #(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q_out,
    output logic             tc,
    output logic             ovf
);

    localparam int             c_pw         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] c_max      = WIDTH'(MAX_VAL);
    localparam logic [c_pw-1:0]  c_pre_last = c_pw'(PRESCALE - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("counter_param: WIDTH out of range 2..32");
        end
        if (MAX_VAL < 1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("counter_param: MAX_VAL out of range 1..2**WIDTH-1");
        end
        if (PRESCALE < 1 || PRESCALE > 256) begin : g_bad_prescale
            $error("counter_param: PRESCALE out of range 1..256");
        end
    endgenerate

    logic [c_pw-1:0] r_pre;
    logic            w_step;
    logic            w_at_bound;

    assign w_step     = count_en && (r_pre == c_pre_last);
    assign w_at_bound = up_dn ? (q_out == c_max) : (q_out == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_out <= '0;
            r_pre <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (clear) begin
            q_out <= '0;
            r_pre <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            q_out <= (load_val > c_max) ? c_max : load_val;
            r_pre <= '0;
            tc    <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (count_en) begin
                r_pre <= w_step ? '0 : r_pre + 1'b1;
            end
            if (w_step) begin
                if (w_at_bound) begin
                    // Boundary hit: flag it, then either hold or jump to the opposite end.
                    tc  <= 1'b1;
                    ovf <= 1'b1;
                    if (!sat_mode) begin
                        q_out <= up_dn ? '0 : c_max;
                    end
                end else begin
                    q_out <= up_dn ? q_out + 1'b1 : q_out - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_param
// Description : Directed + randomized bench for counter_param (PRESCALE 1 and 3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_param;

    localparam int c_w   = 4;
    localparam int c_max = 9;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           count_en = 1'b0;
    logic           up_dn = 1'b1;
    logic           sat_mode = 1'b0;
    logic           clear = 1'b0;
    logic           load = 1'b0;
    logic [c_w-1:0] load_val = '0;
    logic [c_w-1:0] q_out [2];
    logic           tc    [2];
    logic           ovf   [2];

    int passes = 0;
    int total  = 0;

    int ps   [2] = '{1, 3};
    int mq   [2];
    int mpre [2];
    int mtc  [2];
    int movf [2];

    always #5 clk = ~clk;

    counter_param #(.WIDTH(c_w), .MAX_VAL(c_max), .PRESCALE(1)) u_p1 (
        .clk(clk), .reset(reset), .count_en(count_en), .up_dn(up_dn),
        .sat_mode(sat_mode), .clear(clear), .load(load), .load_val(load_val),
        .q_out(q_out[0]), .tc(tc[0]), .ovf(ovf[0])
    );

    counter_param #(.WIDTH(c_w), .MAX_VAL(c_max), .PRESCALE(3)) u_p3 (
        .clk(clk), .reset(reset), .count_en(count_en), .up_dn(up_dn),
        .sat_mode(sat_mode), .clear(clear), .load(load), .load_val(load_val),
        .q_out(q_out[1]), .tc(tc[1]), .ovf(ovf[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i] = 0; mpre[i] = 0; mtc[i] = 0; movf[i] = 0;
        end
    endfunction

    // Reference behaviour: count enabled edges modulo PRESCALE; every PRESCALE-th one moves the value.
    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            if (clear) begin
                mq[i] = 0; mpre[i] = 0; mtc[i] = 0; movf[i] = 0;
            end else if (load) begin
                mq[i] = (int'(load_val) > c_max) ? c_max : int'(load_val);
                mpre[i] = 0; mtc[i] = 0;
            end else begin
                mtc[i] = 0;
                if (count_en) begin
                    mpre[i] = (mpre[i] + 1) % ps[i];
                    if (mpre[i] == 0) begin
                        if (up_dn) begin
                            if (mq[i] < c_max) mq[i] = mq[i] + 1;
                            else begin
                                mtc[i] = 1; movf[i] = 1;
                                if (!sat_mode) mq[i] = 0;
                            end
                        end else begin
                            if (mq[i] > 0) mq[i] = mq[i] - 1;
                            else begin
                                mtc[i] = 1; movf[i] = 1;
                                if (!sat_mode) mq[i] = c_max;
                            end
                        end
                    end
                end
            end
        end
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.q%0d", tag, i),   int'(q_out[i]), mq[i]);
            check($sformatf("%s.tc%0d", tag, i),  int'(tc[i]),    mtc[i]);
            check($sformatf("%s.ovf%0d", tag, i), int'(ovf[i]),   movf[i]);
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk) reset = 1'b0;

        // Up, wrap, PRESCALE=1: 0..9 then 0 with tc and sticky ovf
        count_en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            cycle("up_wrap");
            check("up_wrap.q_spec", int'(q_out[0]), k);
        end
        cycle("up_wrap_end");
        check("wrap.q0", int'(q_out[0]), 0);
        check("wrap.tc", int'(tc[0]), 1);
        cycle("after_wrap");
        check("after_wrap.tc", int'(tc[0]), 0);
        check("after_wrap.ovf", int'(ovf[0]), 1);

        // Saturate: 12 more steps from 1 -> holds 9, never 10
        sat_mode = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle("sat");
            check("sat.le_max", int'(q_out[0] <= c_max), 1);
        end
        check("sat.hold", int'(q_out[0]), 9);
        check("sat.tc", int'(tc[0]), 1);

        // Down, wrap from 0
        clear = 1'b1; count_en = 1'b0;
        cycle("clear");
        clear = 1'b0; count_en = 1'b1; up_dn = 1'b0; sat_mode = 1'b0;
        cycle("down1");
        check("down.q9", int'(q_out[0]), 9);
        check("down.tc", int'(tc[0]), 1);
        cycle("down2");
        check("down.q8", int'(q_out[0]), 8);
        load = 1'b1; load_val = 4'd15;
        cycle("load15");
        check("load15.clamp", int'(q_out[0]), 9);
        load = 1'b0;

        // Prescale 3 with enable 1,1,0,1
        clear = 1'b1;
        cycle("clear2");
        clear = 1'b0; up_dn = 1'b1;
        count_en = 1'b1; cycle("pre_e1");
        check("pre.e1", int'(q_out[1]), 0);
        count_en = 1'b1; cycle("pre_e2");
        check("pre.e2", int'(q_out[1]), 0);
        count_en = 1'b0; cycle("pre_off");
        check("pre.off", int'(q_out[1]), 0);
        count_en = 1'b1; cycle("pre_e3");
        check("pre.e3", int'(q_out[1]), 1);

        // clear + load + count_en at q=5, with ovf set beforehand
        load = 1'b1; load_val = 4'd9; count_en = 1'b0;
        cycle("ld9");
        load = 1'b0; count_en = 1'b1;
        cycle("hit");
        load = 1'b1; load_val = 4'd5;
        cycle("ld5");
        check("ld5.ovf_kept", int'(ovf[0]), 1);
        clear = 1'b1; load = 1'b1; load_val = 4'd3;
        cycle("clr_ld");
        check("clr_ld.q", int'(q_out[0]), 0);
        check("clr_ld.ovf", int'(ovf[0]), 0);
        clear = 1'b0;
        cycle("ld3");
        check("ld3.q", int'(q_out[0]), 3);
        load = 1'b0;

        // Asynchronous reset mid-cycle at q=7 with ovf=1
        load = 1'b1; load_val = 4'd9; count_en = 1'b0;
        cycle("ld9b");
        load = 1'b0; count_en = 1'b1;
        cycle("hitb");
        load = 1'b1; load_val = 4'd7;
        cycle("ld7");
        load = 1'b0; count_en = 1'b0;
        check("pre_rst.ovf", int'(ovf[0]), 1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("rst_mid");
        check("rst_mid.q", int'(q_out[0]), 0);
        @(negedge clk) reset = 1'b0;
        count_en = 1'b1;
        cycle("post_rst1");
        cycle("post_rst2");
        check("post_rst.p3_q", int'(q_out[1]), 0);
        cycle("post_rst3");
        check("post_rst.p3_step", int'(q_out[1]), 1);

        // Randomized traffic against the reference model
        for (int k = 0; k < 300; k++) begin
            count_en = 1'($urandom_range(0, 3) != 0);
            up_dn    = 1'($urandom);
            sat_mode = 1'($urandom);
            clear    = ($urandom_range(0, 40) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = 4'($urandom);
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
